keypad_scanner: RTL and testbench

- Scans a 4x4 matrix keypad by driving one column low at a time and reading the active-low rows.
- Debounces the result and emits a one-cycle num/num_valid strobe per distinct key press.
- Sits directly upstream of the LED display stage, which consumes num and num_valid. Codes above 9 are passed through; the display ignores them.

---
 rtl/keypad_scanner.sv | 276 +++++++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low column strobe, synchronizes the rows,
// classifies each full scan and debounces presses/releases into a one-cycle num strobe.
module keypad_scanner #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] num,
    output logic       num_valid,
    output logic       key_down
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_TARGET = CW'(DEBOUNCE_SCANS);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        RES_NONE   = 2'd0,
        RES_SINGLE = 2'd1,
        RES_MULTI  = 2'd2
    } result_t;

    function automatic logic [3:0] key_code(input logic [1:0] c, input logic [1:0] r);
        logic [3:0] code;
        case ({c, r})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h4;
            4'b00_10: code = 4'h7;
            4'b00_11: code = 4'h0;
            4'b01_00: code = 4'h2;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h8;
            4'b01_11: code = 4'hF;
            4'b10_00: code = 4'h3;
            4'b10_01: code = 4'h6;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hE;
            4'b11_00: code = 4'hA;
            4'b11_01: code = 4'hB;
            4'b11_10: code = 4'hC;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

    // ------------------------------------------------------------------
    // Row synchronizer
    // ------------------------------------------------------------------
    logic [3:0] row_meta_reg;
    logic [3:0] row_sync_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta_reg <= 4'b1111;
            row_sync_reg <= 4'b1111;
        end else begin
            row_meta_reg <= row;
            row_sync_reg <= row_meta_reg;
        end
    end

    // ------------------------------------------------------------------
    // Column scan timing
    // ------------------------------------------------------------------
    logic [DW-1:0] dwell_reg;
    logic [1:0]    col_idx_reg;
    logic [1:0]    col_idx_next;
    logic [3:0]    col_reg;
    logic          sample_tick;
    logic          scan_done;

    assign sample_tick  = (dwell_reg == DWELL_LAST);
    assign scan_done    = sample_tick && (col_idx_reg == 2'd3);
    assign col_idx_next = col_idx_reg + 2'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            dwell_reg   <= '0;
            col_idx_reg <= 2'd0;
            col_reg     <= 4'b1110;
        end else if (sample_tick) begin
            dwell_reg   <= '0;
            col_idx_reg <= col_idx_next;
            col_reg     <= ~(4'b0001 << col_idx_next);
        end else begin
            dwell_reg   <= dwell_reg + DW'(1);
        end
    end

    assign col = col_reg;

    // ------------------------------------------------------------------
    // Per-column contact decode
    // ------------------------------------------------------------------
    logic [3:0] row_closed;
    logic [3:0] row_key [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_row
        assign row_closed[gi] = ~row_sync_reg[gi];
        assign row_key[gi]    = key_code(col_idx_reg, 2'(gi));
    end

    logic [1:0] col_hits;
    logic [3:0] col_key;

    always_comb begin
        col_key = 4'h0;
        for (int r = 3; r >= 0; r--) begin
            if (row_closed[r]) begin
                col_key = row_key[r];
            end
        end
        if (row_closed == 4'b0000) begin
            col_hits = 2'd0;
        end else if ((row_closed & (row_closed - 4'd1)) == 4'b0000) begin
            col_hits = 2'd1;
        end else begin
            col_hits = 2'd2;
        end
    end

    // ------------------------------------------------------------------
    // Per-scan accumulator; contact count saturates at 2 (= MULTI)
    // ------------------------------------------------------------------
    logic [1:0] acc_hits_reg;
    logic [3:0] acc_key_reg;
    logic [2:0] hit_sum;
    logic [1:0] scan_hits;
    logic [3:0] scan_key;
    result_t    scan_result;

    always_comb begin
        hit_sum     = {1'b0, acc_hits_reg} + {1'b0, col_hits};
        scan_hits   = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        scan_key    = (acc_hits_reg == 2'd0) ? col_key : acc_key_reg;
        scan_result = RES_NONE;
        if (scan_hits == 2'd1) begin
            scan_result = RES_SINGLE;
        end else if (scan_hits == 2'd2) begin
            scan_result = RES_MULTI;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_hits_reg <= 2'd0;
            acc_key_reg  <= 4'h0;
        end else if (scan_done) begin
            acc_hits_reg <= 2'd0;
            acc_key_reg  <= 4'h0;
        end else if (sample_tick) begin
            acc_hits_reg <= scan_hits;
            acc_key_reg  <= scan_key;
        end
    end

    // ------------------------------------------------------------------
    // Debounce FSM: state register / next-state / outputs
    // ------------------------------------------------------------------
    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next, cnt_inc;
    logic [3:0]    cand_reg, cand_next;
    logic [3:0]    num_reg, num_next;
    logic          num_valid_reg, num_valid_next;
    logic          key_down_reg, key_down_next;
    logic          accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            cand_reg      <= 4'h0;
            num_reg       <= 4'h0;
            num_valid_reg <= 1'b0;
            key_down_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            cand_reg      <= cand_next;
            num_reg       <= num_next;
            num_valid_reg <= num_valid_next;
            key_down_reg  <= key_down_next;
        end
    end

    // cnt_reg stays below DEB_TARGET in every state, so cnt_inc never wraps.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        cand_next  = cand_reg;
        accept     = 1'b0;
        cnt_inc    = cnt_reg + CNT_ONE;
        if (scan_done) begin
            case (state_reg)
                IDLE: begin
                    if (scan_result == RES_SINGLE) begin
                        cand_next = scan_key;
                        if (CNT_ONE >= DEB_TARGET) begin
                            accept     = 1'b1;
                            state_next = HELD;
                            cnt_next   = '0;
                        end else begin
                            state_next = DEBOUNCE;
                            cnt_next   = CNT_ONE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (scan_result == RES_SINGLE && scan_key == cand_reg) begin
                        if (cnt_inc >= DEB_TARGET) begin
                            accept     = 1'b1;
                            state_next = HELD;
                            cnt_next   = '0;
                        end else begin
                            cnt_next   = cnt_inc;
                        end
                    end else begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end
                end
                HELD: begin
                    if (scan_result == RES_NONE) begin
                        if (CNT_ONE >= DEB_TARGET) begin
                            state_next = IDLE;
                            cnt_next   = '0;
                        end else begin
                            state_next = RELEASE;
                            cnt_next   = CNT_ONE;
                        end
                    end
                end
                RELEASE: begin
                    if (scan_result == RES_NONE) begin
                        if (cnt_inc >= DEB_TARGET) begin
                            state_next = IDLE;
                            cnt_next   = '0;
                        end else begin
                            cnt_next   = cnt_inc;
                        end
                    end else begin
                        state_next = HELD;
                        cnt_next   = '0;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_comb begin
        num_next       = accept ? cand_next : num_reg;
        num_valid_next = accept;
        key_down_next  = (state_next == HELD) || (state_next == RELEASE);
    end

    assign num       = num_reg;
    assign num_valid = num_valid_reg;
    assign key_down  = key_down_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a keypad model drives the rows, stimulus pushes the
// expected key codes into a queue and a monitor pops one per num_valid strobe.
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;
    localparam int SCAN_CYC = 4 * SCAN_DIV;

    logic       clk;
    logic       rst;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] num;
    logic       num_valid;
    logic       key_down;

    logic [3:0] pressed [4];
    logic [3:0] exp_q [$];
    int         checks;
    int         errors;
    int         cyc;
    int         pulse_cyc;
    logic       prev_valid;

    keypad_scanner #(
        .SCAN_DIV      (SCAN_DIV),
        .DEBOUNCE_SCANS(DEB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .row      (row),
        .col      (col),
        .num      (num),
        .num_valid(num_valid),
        .key_down (key_down)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (pressed[c][r] === 1'b1 && col[c] === 1'b0) begin
                    row[r] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic key(input int c, input int r, input logic v);
        pressed[c][r] = v;
    endtask

    task automatic wait_scans(input int n);
        repeat (SCAN_CYC * n) @(negedge clk);
    endtask

    // Monitor: every strobe must match the oldest expected code.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (num_valid === 1'b1) begin
                check("num_valid_gap", {31'd0, prev_valid}, 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse actual num=%0h required no pulse (t=%0t)", num, $time);
                end else begin
                    check("pulse_num", {28'd0, num}, {28'd0, exp_q.pop_front()});
                end
                check("pulse_key_down", {31'd0, key_down}, 32'd1);
                pulse_cyc = cyc;
            end
            prev_valid = num_valid;
        end
    end

    initial begin
        int t0;
        logic [3:0] exp_col;
        checks     = 0;
        errors     = 0;
        cyc        = 0;
        pulse_cyc  = -1;
        prev_valid = 1'b0;
        for (int c = 0; c < 4; c++) pressed[c] = 4'h0;
        rst = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_col", {28'd0, col}, 32'hE);
        check("rst_num", {28'd0, num}, 32'h0);
        check("rst_num_valid", {31'd0, num_valid}, 32'd0);
        check("rst_key_down", {31'd0, key_down}, 32'd0);
        rst = 1'b0;

        // Column walk, sampled mid-dwell
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            exp_col = 4'b1111;
            exp_col[i % 4] = 1'b0;
            check("col_walk", {28'd0, col}, {28'd0, exp_col});
            repeat (SCAN_DIV) @(negedge clk);
        end

        // Single press of 8, held 20 scans
        exp_q.push_back(4'h8);
        t0 = cyc;
        key(1, 2, 1'b1);
        wait_scans(20);
        check("single_latency_ok", {31'd0, (pulse_cyc > t0) && (pulse_cyc - t0 <= 4 * SCAN_CYC)}, 32'd1);
        check("single_key_down", {31'd0, key_down}, 32'd1);
        check("single_num_held", {28'd0, num}, 32'h8);
        key(1, 2, 1'b0);
        wait_scans(5);
        check("single_released", {31'd0, key_down}, 32'd0);

        // Bounce on key 5: alternating scans never reach three in a row
        for (int i = 0; i < 10; i++) begin
            key(1, 1, (i % 2) == 0);
            wait_scans(1);
            check("bounce_key_down", {31'd0, key_down}, 32'd0);
        end
        key(1, 1, 1'b0);
        wait_scans(4);

        // Multi-key 5+9, then release 5
        key(1, 1, 1'b1);
        key(2, 2, 1'b1);
        wait_scans(6);
        check("multi_key_down", {31'd0, key_down}, 32'd0);
        exp_q.push_back(4'h9);
        key(1, 1, 1'b0);
        wait_scans(6);
        check("multi_then_9_down", {31'd0, key_down}, 32'd1);
        key(2, 2, 1'b0);
        wait_scans(5);
        check("multi_released", {31'd0, key_down}, 32'd0);

        // Key 0 twice with a full release debounce between
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(4'h0);
            key(0, 3, 1'b1);
            wait_scans(6);
            key(0, 3, 1'b0);
            wait_scans(5);
            check("repress_released", {31'd0, key_down}, 32'd0);
        end

        // Key 0 with a 2-scan release gap: one strobe only
        exp_q.push_back(4'h0);
        key(0, 3, 1'b1);
        wait_scans(6);
        key(0, 3, 1'b0);
        for (int i = 0; i < 2; i++) begin
            repeat (SCAN_CYC / 2) @(negedge clk);
            check("short_release_key_down", {31'd0, key_down}, 32'd1);
            repeat (SCAN_CYC / 2) @(negedge clk);
        end
        key(0, 3, 1'b1);
        wait_scans(3);
        check("short_release_still_held", {31'd0, key_down}, 32'd1);
        key(0, 3, 1'b0);
        wait_scans(5);
        check("short_release_done", {31'd0, key_down}, 32'd0);

        // Reset while key 4 is held
        exp_q.push_back(4'h4);
        key(0, 1, 1'b1);
        wait_scans(6);
        check("held_before_rst", {31'd0, key_down}, 32'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_col", {28'd0, col}, 32'hE);
        check("midrst_num", {28'd0, num}, 32'h0);
        check("midrst_num_valid", {31'd0, num_valid}, 32'd0);
        check("midrst_key_down", {31'd0, key_down}, 32'd0);
        exp_q.push_back(4'h4);
        rst = 1'b0;
        t0 = cyc;
        wait_scans(6);
        check("after_rst_latency_ok", {31'd0, (pulse_cyc > t0) && (pulse_cyc - t0 <= 4 * SCAN_CYC)}, 32'd1);
        check("after_rst_num", {28'd0, num}, 32'h4);
        key(0, 1, 1'b0);
        wait_scans(5);

        // Letter key A
        exp_q.push_back(4'hA);
        key(3, 0, 1'b1);
        wait_scans(6);
        key(3, 0, 1'b0);
        wait_scans(5);
        check("letter_num_held", {28'd0, num}, 32'hA);
        check("letter_released", {31'd0, key_down}, 32'd0);

        check("missing_pulses", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
